// File: rtl/temp_sample_logger.sv
// Temperature sample logger: averages blocks of 2^AVG_LOG2 ADC samples,
// writes each block average to a circular RAM, tracks the running min/max
// and raises an over-temperature alarm with hysteresis.
module temp_sample_logger #(
    parameter int DATA_W   = 12,
    parameter int AVG_LOG2 = 4,
    parameter int ADDR_W   = 8,
    parameter int ALARM_HI = 3000,
    parameter int ALARM_LO = 2900
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              adc_valid,
    input  logic [DATA_W-1:0] adc_data,
    output logic [ADDR_W-1:0] ram_addr,
    output logic [DATA_W-1:0] ram_data,
    output logic              ram_wren,
    output logic              avg_valid,
    output logic [DATA_W-1:0] avg_data,
    output logic [DATA_W-1:0] min_data,
    output logic [DATA_W-1:0] max_data,
    output logic              alarm,
    output logic              wrapped
);

    localparam int ACC_W = DATA_W + AVG_LOG2;
    localparam int CNT_W = AVG_LOG2 + 1;
    localparam logic [CNT_W-1:0]  LAST_CNT = CNT_W'((1 << AVG_LOG2) - 1);
    localparam logic [DATA_W-1:0] HI_TH    = DATA_W'(ALARM_HI);
    localparam logic [DATA_W-1:0] LO_TH    = DATA_W'(ALARM_LO);

    typedef enum logic {
        ACCUM,
        WRITE
    } state_t;

    state_t              state;
    logic [ACC_W-1:0]    acc;
    logic [CNT_W-1:0]    count;
    logic [ADDR_W-1:0]   wptr;
    logic [ACC_W-1:0]    sum_next;
    logic [DATA_W-1:0]   avg_next;

    // Sum including the sample offered this cycle, and its truncated average.
    always_comb begin
        sum_next = acc + ACC_W'(adc_data);
        avg_next = DATA_W'(sum_next >> AVG_LOG2);
    end

    assign ram_addr = wptr;

    // Block FSM: accumulate samples, then spend one cycle writing the average.
    // The write strobes and data are registered on the edge that accepts the
    // last sample so they are visible throughout the WRITE cycle.
    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= ACCUM;
            acc       <= '0;
            count     <= '0;
            wptr      <= '0;
            ram_wren  <= 1'b0;
            ram_data  <= '0;
            avg_valid <= 1'b0;
            avg_data  <= '0;
            alarm     <= 1'b0;
            wrapped   <= 1'b0;
        end else begin
            case (state)
                ACCUM: begin
                    if (adc_valid) begin
                        if (count == LAST_CNT) begin
                            state     <= WRITE;
                            acc       <= sum_next;
                            count     <= '0;
                            ram_wren  <= 1'b1;
                            avg_valid <= 1'b1;
                            ram_data  <= avg_next;
                            avg_data  <= avg_next;
                        end else begin
                            acc   <= sum_next;
                            count <= count + 1'b1;
                        end
                    end
                end
                WRITE: begin
                    state     <= ACCUM;
                    ram_wren  <= 1'b0;
                    avg_valid <= 1'b0;
                    wptr      <= wptr + 1'b1;
                    if (wptr == '1)
                        wrapped <= 1'b1;
                    if (avg_data > HI_TH)
                        alarm <= 1'b1;
                    else if (avg_data < LO_TH)
                        alarm <= 1'b0;
                    // A sample arriving during WRITE opens the next block.
                    if (adc_valid) begin
                        acc   <= ACC_W'(adc_data);
                        count <= CNT_W'(1);
                    end else begin
                        acc   <= '0;
                        count <= '0;
                    end
                end
                default: state <= ACCUM;
            endcase
        end
    end

    // Running extremes over every accepted sample, independent of the FSM.
    always_ff @(posedge clk) begin
        if (rst) begin
            min_data <= '1;
            max_data <= '0;
        end else if (adc_valid) begin
            if (adc_data < min_data)
                min_data <= adc_data;
            if (adc_data > max_data)
                max_data <= adc_data;
        end
    end

endmodule

// File: doc/temp_sample_logger.md
TEMP_SAMPLE_LOGGER -- requirements
Module: temp_sample_logger

Interface
REQ-001 Parameter DATA_W, default 12, ADC sample width.
REQ-002 Parameter AVG_LOG2, default 4, log2 of samples per average block (block size N = 2^AVG_LOG2).
REQ-003 Parameter ADDR_W, default 8, RAM address width (depth 2^ADDR_W).
REQ-004 Parameter ALARM_HI, default 3000, alarm set threshold.
REQ-005 Parameter ALARM_LO, default 2900, alarm clear threshold; ALARM_LO <= ALARM_HI is required.
REQ-006 The block SHALL use one clock and a synchronous, active-high reset.
REQ-007 clk  in  1  system clock; all logic is on its rising edge.
REQ-008 rst  in  1  synchronous active-high reset.
REQ-009 adc_valid  in  1  one-cycle strobe; adc_data is valid.
REQ-010 adc_data  in  DATA_W  ADC temperature sample.
REQ-011 ram_addr  out  ADDR_W  RAM write address.
REQ-012 ram_data  out  DATA_W  RAM write data.
REQ-013 ram_wren  out  1  RAM write enable, one-cycle pulse.
REQ-014 avg_valid  out  1  one-cycle pulse, new average on avg_data.
REQ-015 avg_data  out  DATA_W  most recent block average, held between blocks.
REQ-016 min_data / max_data  out  DATA_W each  running minimum / maximum sample since reset.
REQ-017 alarm  out  1  over-temperature flag with hysteresis.
REQ-018 wrapped  out  1  sticky; RAM write pointer has wrapped at least once.

Function
REQ-019 FSM states: ACCUM and WRITE; reset state ACCUM.
REQ-020 ACCUM: each adc_valid adds adc_data to a (DATA_W+AVG_LOG2)-bit accumulator and increments sample count; no overflow possible.
REQ-021 On the clock edge accepting the Nth sample, the FSM SHALL go to WRITE.
REQ-022 WRITE lasts exactly one cycle: ram_wren=1, avg_valid=1, ram_addr=write pointer, ram_data=avg_data=accumulator>>AVG_LOG2 (truncating); then return to ACCUM.
REQ-023 Latency: ram_wren/avg_valid assert the cycle immediately after the Nth adc_valid.
REQ-024 Write pointer increments by 1 at the end of WRITE, modulo 2^ADDR_W (2^ADDR_W-1 -> 0); wrapped sets on that transition and stays set until reset.
REQ-025 adc_valid during WRITE SHALL NOT be dropped: it loads the accumulator with adc_data and sets count=1 for the next block.
REQ-026 Outside WRITE: ram_wren=0, avg_valid=0; ram_addr shows the write pointer; ram_data and avg_data hold their last values.
REQ-027 min_data/max_data SHALL update on every accepted sample, in either state, visible the cycle after adc_valid; ties leave the value unchanged.
REQ-028 alarm SHALL set when a written average > ALARM_HI, clear when < ALARM_LO, and otherwise hold; it updates on the edge ending WRITE.
REQ-029 The block has no backpressure: the consumer SHALL accept ram_wren every cycle it is asserted.

Reset
REQ-030 On rst=1 at a clock edge: FSM=ACCUM, accumulator=0, count=0, write pointer=0, ram_wren=0, ram_data=0, avg_valid=0, avg_data=0, min_data=all ones, max_data=0, alarm=0, wrapped=0.
REQ-031 rst overrides adc_valid in the same cycle; a partial block is discarded, and a reset asserted in WRITE suppresses that write.

Verification (defaults)
REQ-032 16 adc_valid strobes with data 12'h800 -> the cycle after the 16th: ram_wren=1, ram_addr=0, ram_data=12'h800, avg_valid=1; the next block writes to addr 1.
REQ-033 Samples 0,1,...,15 -> average 120/16 = 7 (truncated), written to addr 0; min_data=0, max_data=15.
REQ-034 Complete 256 blocks -> the 256th write uses addr 255, wrapped=1 after it, and the 257th write uses addr 0.
REQ-035 Block averages 3001, 2950, 2899 -> alarm=1, stays 1, then 0, each changing after that block's WRITE cycle.
REQ-036 adc_valid asserted in the WRITE cycle -> it counts as sample 1 of the next block, and the next write follows after 15 more strobes.
REQ-037 rst after 10 samples -> no write occurs; the next write requires 16 fresh samples to addr 0, and min_data/max_data are re-initialised.
